// File: rtl/elastbuf_flow_ctrl_if.sv
// Handshake and buffer-control bundle between the elasticity buffer
// sequencer, the lane-merge write side, the packet-decoder read side
// and the shift-register buffer itself.
// The master modport is the sequencer's view. The slave modport is the
// view of the surrounding logic.
interface elastbuf_flow_ctrl_if #(
  parameter int LVL_W = 3
);
  logic             in_valid;
  logic             in_sop;
  logic             in_eop;
  logic             in_ready;
  logic             out_ready;
  logic             out_valid;
  logic             out_eop;
  logic             sw_clr;
  logic             buf_write;
  logic             buf_read;
  logic             buf_clr;
  logic             buf_emptyz;
  logic             buf_fullz;
  logic [LVL_W-1:0] level;
  logic [2:0]       state;
  logic             err_ovf;
  logic             err_proto;
  logic             err_udf;

  modport master (
    input  in_valid, in_sop, in_eop, out_ready, sw_clr, buf_emptyz, buf_fullz,
    output in_ready, out_valid, out_eop, buf_write, buf_read, buf_clr,
           level, state, err_ovf, err_proto, err_udf
  );

  modport slave (
    output in_valid, in_sop, in_eop, out_ready, sw_clr, buf_emptyz, buf_fullz,
    input  in_ready, out_valid, out_eop, buf_write, buf_read, buf_clr,
           level, state, err_ovf, err_proto, err_udf
  );
endinterface

// File: rtl/elastbuf_flow_ctrl.sv
// Flow controller for one shift-register elasticity buffer.
// The controller issues the buffer write, read and clear strobes. It holds
// off reading until a start fill level is reached, so that jitter is absorbed.
// It tracks packet boundaries. It flags overflow, starvation and framing
// errors, and it recovers from them by flushing the buffer.
module elastbuf_flow_ctrl #(
  parameter int ADDR_DEPTH = 4,
  parameter int LVL_W      = 3,
  parameter int START_LVL  = 2,
  parameter int UDF_TO     = 15,
  parameter int TO_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  elastbuf_flow_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    FLUSH  = 3'd4
  } state_e;

  state_e           state_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic [TO_W-1:0]  starve_q;
  logic             eop_seen_q;
  logic             err_ovf_q;
  logic             err_proto_q;
  logic             err_udf_q;

  logic in_ready;
  logic accept;
  logic wr;
  logic rd;
  logic out_valid;
  logic clr;
  logic starved;
  logic ovf_hit;
  logic udf_hit;

  // Buffer strobes and next occupancy. A non-sop word seen in IDLE is
  // accepted but never written, so stray words between packets are dropped.
  always_comb begin
    in_ready  = bus.buf_fullz & (state_q inside {IDLE, FILL, STREAM});
    accept    = bus.in_valid & in_ready;
    wr        = accept & ((state_q != IDLE) | bus.in_sop);
    out_valid = bus.buf_emptyz & (state_q inside {STREAM, DRAIN});
    rd        = out_valid & bus.out_ready;
    clr       = bus.sw_clr | (state_q == FLUSH);
    starved   = ~bus.buf_emptyz & ~wr;
    ovf_hit   = bus.in_valid & ~bus.buf_fullz;
    udf_hit   = starved & (starve_q == TO_W'(UDF_TO - 1));
    if (clr) begin
      level_d = '0;
    end else begin
      level_d = level_q + LVL_W'(wr) - LVL_W'(rd);
    end
  end

  // Packet sequencing FSM with the occupancy, starvation and error registers.
  // The error checks are ordered so that only the highest-priority error fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      level_q     <= '0;
      starve_q    <= '0;
      eop_seen_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_proto_q <= 1'b0;
      err_udf_q   <= 1'b0;
    end else begin
      level_q     <= level_d;
      err_ovf_q   <= 1'b0;
      err_proto_q <= 1'b0;
      err_udf_q   <= 1'b0;
      if (bus.sw_clr) begin
        state_q    <= IDLE;
        eop_seen_q <= 1'b0;
        starve_q   <= '0;
      end else begin
        starve_q <= ((state_q == STREAM) && starved) ? starve_q + 1'b1 : '0;
        case (state_q)
          IDLE: begin
            if (wr) begin
              if (bus.in_eop) begin
                eop_seen_q <= 1'b1;
                state_q    <= DRAIN;
              end else begin
                state_q <= FILL;
              end
            end
          end
          FILL: begin
            if (ovf_hit) begin
              err_ovf_q <= 1'b1;
              state_q   <= FLUSH;
            end else if (accept & bus.in_sop) begin
              err_proto_q <= 1'b1;
              state_q     <= FLUSH;
            end else if (wr & bus.in_eop) begin
              eop_seen_q <= 1'b1;
              state_q    <= DRAIN;
            end else if (level_d >= LVL_W'(START_LVL)) begin
              state_q <= STREAM;
            end
          end
          STREAM: begin
            if (ovf_hit) begin
              err_ovf_q <= 1'b1;
              state_q   <= FLUSH;
            end else if (bus.in_valid & bus.in_sop) begin
              err_proto_q <= 1'b1;
              state_q     <= FLUSH;
            end else if (udf_hit) begin
              err_udf_q <= 1'b1;
              state_q   <= FLUSH;
            end else if (wr & bus.in_eop) begin
              eop_seen_q <= 1'b1;
              state_q    <= DRAIN;
            end
          end
          DRAIN: begin
            if (level_d == '0) begin
              eop_seen_q <= 1'b0;
              state_q    <= IDLE;
            end
          end
          FLUSH: begin
            eop_seen_q <= 1'b0;
            state_q    <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  // The occupancy count must never run past the physical buffer depth.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (level_q <= LVL_W'(ADDR_DEPTH));
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.buf_write = wr;
  assign bus.buf_read  = rd;
  assign bus.buf_clr   = clr;
  assign bus.out_valid = out_valid;
  assign bus.out_eop   = out_valid & (state_q == DRAIN) & eop_seen_q & (level_q == LVL_W'(1));
  assign bus.level     = level_q;
  assign bus.state     = state_q;
  assign bus.err_ovf   = err_ovf_q;
  assign bus.err_proto = err_proto_q;
  assign bus.err_udf   = err_udf_q;

endmodule

// File: doc/elastbuf_flow_ctrl.md
Name: elastbuf_flow_ctrl

Overview:
- Sequences one shift-register elasticity buffer: ADDR_DEPTH entries, active-low empty/full flags, one-entry-left almost-full flag, synchronous clear.
- Sits between the lane-merge write side and the packet-decoder read side.
- Generates buffer write, read and clear strobes, and enforces a start threshold before any read so jitter is absorbed.
- Tracks packet boundaries and detects overflow, underflow timeout and framing errors; recovers by flushing the buffer.

Parameters:
- ADDR_DEPTH, 4, buffer depth in entries (≥2); must match the attached buffer.
- LVL_W, 3, level counter width; holds 0..ADDR_DEPTH.
- START_LVL, 2, fill level that starts reading (1..ADDR_DEPTH).
- UDF_TO, 15, consecutive starved cycles in STREAM that flag underflow (≥1).
- TO_W, 4, starvation counter width; holds UDF_TO.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream word present.
- in_sop  in  1  word is first of packet.
- in_eop  in  1  word is last of packet (may coincide with sop).
- in_ready  out  1  upstream word accepted when in_valid & in_ready.
- out_ready  in  1  downstream can take a word.
- out_valid  out  1  buffer head word valid for downstream.
- out_eop  out  1  head word is last of packet.
- sw_clr  in  1  synchronous software flush.
- buf_write  out  1  buffer write enable.
- buf_read  out  1  buffer read enable.
- buf_clr  out  1  buffer synchronous clear.
- buf_emptyz  in  1  buffer not empty.
- buf_fullz  in  1  buffer not full.
- level  out  LVL_W  registered occupancy.
- state  out  3  IDLE=0, FILL=1, STREAM=2, DRAIN=3, FLUSH=4.
- err_ovf / err_udf / err_proto  out  1 each  one-cycle registered error pulses.

Behaviour:
Reset:
- state=IDLE; level=0; eop_seen=0; starvation counter=0; all err_* outputs 0.
- Combinational outputs evaluate with state=IDLE.

Strobes (combinational):
- in_ready = buf_fullz & state∈{IDLE, FILL, STREAM}.
- buf_write = in_valid & in_ready & (state≠IDLE | in_sop). Non-sop words in IDLE are consumed and dropped.
- out_valid = buf_emptyz & state∈{STREAM, DRAIN}.
- buf_read = out_valid & out_ready. Never read when empty; never write when full, even with a read in the same cycle, because the buffer drops the write in that case.
- out_eop = out_valid & state==DRAIN & level==1.
- buf_clr = sw_clr | state==FLUSH.

Level counter:
- next_level = level + buf_write − buf_read. Simultaneous write and read leaves level unchanged.
- buf_clr forces level to 0.
- level must always equal the buffer occupancy.

Transitions (evaluated each cycle):
- sw_clr has top priority: go to IDLE, clear eop_seen and the counter. No error pulse.
- IDLE → FILL on buf_write. If that sop word also carries eop: set eop_seen and go to DRAIN.
- FILL → DRAIN when the written word has eop.
- FILL → STREAM when next_level ≥ START_LVL.
- FILL → FLUSH, with err_proto, on an accepted in_sop.
- STREAM → DRAIN when the written word has eop.
- STREAM → FLUSH, with err_proto, on in_valid & in_sop.
- STREAM → FLUSH, with err_udf, when the counter reaches UDF_TO. The counter increments on cycles with buf_emptyz=0 and no buf_write, and resets otherwise.
- FILL or STREAM → FLUSH, with err_ovf, on in_valid & ~buf_fullz (the word is lost).
- DRAIN → IDLE when next_level==0. In DRAIN, in_ready=0 and input is stalled.
- FLUSH lasts exactly one cycle (buf_clr=1), then → IDLE.
- Multiple errors in one cycle: err_ovf > err_proto > err_udf; only one pulse fires.

Latency:
- A word written in cycle N is readable in N+1 at the earliest, once in STREAM or DRAIN.
- With START_LVL=2 and back-to-back input, the first buf_read occurs 2 cycles after the sop write.

Reset mid-packet returns everything to reset values immediately. The attached buffer is reset by the same reset.

Test Plan:
- Reset, then 6-word packet (sop on w0, eop on w5), out_ready=1 → reads start 2 cycles after sop; level peaks at 2; out_eop with w5; state returns to IDLE; no errors.
- Single-word packet (sop & eop together) → IDLE→DRAIN; one read with out_eop=1; level 0 → 0 → 1 → 0.
- out_ready=0, continuous input with ADDR_DEPTH=4 → in_ready drops after 4 writes; forcing in_valid with buf_fullz=0 → err_ovf pulse, buf_clr for 1 cycle, level=0, IDLE.
- Input stops mid-packet in STREAM after buffer empties → err_udf asserted exactly 15 cycles after the buffer empties; FLUSH; IDLE.
- New sop before eop in STREAM → err_proto; non-sop word in IDLE → dropped, no write, no error.
- Simultaneous read and write at level 2 → level stays 2; sw_clr mid-STREAM → buf_clr=1, level=0, IDLE, no error pulse.
